// File: rtl/icache_fetch_responder.sv
// Fetch-side instruction responder backed by a small fully associative line buffer with miss refill.
// Optional macro ICACHE_MISALIGN_CHECK_EN raises an address-misaligned exception for vaddr[1:0] != 0.
module icache_fetch_responder #(
    parameter int NUM_LINES = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    input  logic [39:0]  req_vaddr_i,
    output logic         req_ready_o,
    input  logic         flush_i,
    output logic         resp_valid_o,
    output logic [31:0]  resp_data_o,
    output logic         resp_ex_valid_o,
    output logic [63:0]  resp_ex_cause_o,
    output logic [63:0]  resp_ex_origin_o,
    output logic         mem_req_valid_o,
    output logic [39:0]  mem_req_addr_o,
    input  logic         mem_req_ready_i,
    input  logic         mem_resp_valid_i,
    input  logic [127:0] mem_resp_data_i,
    input  logic         mem_resp_error_i
);
    localparam int PTR_W = $clog2(NUM_LINES);

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT, KILL} state_e;

    state_e             state_q, state_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [35:0]        tag_q  [NUM_LINES];
    logic [127:0]       line_q [NUM_LINES];
    logic [PTR_W-1:0]   replPtr_q;
    logic [39:0]        vaddr_q, vaddr_d;
    logic               respValid_q, respValid_d;
    logic [31:0]        respData_q, respData_d;
    logic               respExValid_q, respExValid_d;
    logic [63:0]        respExCause_q, respExCause_d;
    logic [63:0]        respExOrigin_q, respExOrigin_d;
    logic               fillEn;
    logic               hit;
    logic [127:0]       hitLine;
    logic               misaligned;
    logic               reqAccept;

    function automatic logic [31:0] selWord(input logic [127:0] line, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hitLine = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == req_vaddr_i[39:4])) begin
                hit     = 1'b1;
                hitLine = line_q[i];
            end
        end
    end

    // Ready is also held low while reset is asserted so every output reads 0 in reset.
    assign req_ready_o     = (state_q == IDLE) && !flush_i && !rst_i;
    assign reqAccept       = req_valid_i && req_ready_o;
    assign mem_req_valid_o = (state_q == MISS_REQ);
    assign mem_req_addr_o  = {vaddr_q[39:4], 4'b0000};

    always_comb begin
        state_d        = state_q;
        vaddr_d        = vaddr_q;
        respValid_d    = 1'b0;
        respData_d     = '0;
        respExValid_d  = 1'b0;
        respExCause_d  = '0;
        respExOrigin_d = '0;
        fillEn         = 1'b0;
        misaligned     = 1'b0;
`ifdef ICACHE_MISALIGN_CHECK_EN
        misaligned     = (req_vaddr_i[1:0] != 2'b00);
`endif
        case (state_q)
            IDLE: begin
                if (reqAccept) begin
                    if (misaligned) begin
                        respValid_d    = 1'b1;
                        respExValid_d  = 1'b1;
                        respExCause_d  = 64'd0;
                        respExOrigin_d = {24'b0, req_vaddr_i};
                    end else if (hit) begin
                        respValid_d = 1'b1;
                        respData_d  = selWord(hitLine, req_vaddr_i[3:2]);
                    end else begin
                        vaddr_d = req_vaddr_i;
                        state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                // A flush coinciding with the handshake still has a response in flight to swallow.
                if (flush_i) begin
                    state_d = mem_req_ready_i ? KILL : IDLE;
                end else if (mem_req_ready_i) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        respValid_d = 1'b1;
                        if (mem_resp_error_i) begin
                            respExValid_d  = 1'b1;
                            respExCause_d  = 64'd1;
                            respExOrigin_d = {24'b0, vaddr_q};
                        end else begin
                            fillEn     = 1'b1;
                            respData_d = selWord(mem_resp_data_i, vaddr_q[3:2]);
                        end
                    end
                end else if (flush_i) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                if (mem_resp_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            vaddr_q        <= '0;
            respValid_q    <= 1'b0;
            respData_q     <= '0;
            respExValid_q  <= 1'b0;
            respExCause_q  <= '0;
            respExOrigin_q <= '0;
        end else begin
            state_q        <= state_d;
            vaddr_q        <= vaddr_d;
            respValid_q    <= respValid_d;
            respData_q     <= respData_d;
            respExValid_q  <= respExValid_d;
            respExCause_q  <= respExCause_d;
            respExOrigin_q <= respExOrigin_d;
        end
    end

    // Flush invalidates every line but deliberately leaves the replacement pointer alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            replPtr_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i]  <= '0;
                line_q[i] <= '0;
            end
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end else if (fillEn) begin
                valid_q[replPtr_q] <= 1'b1;
            end
            if (fillEn) begin
                tag_q[replPtr_q]  <= vaddr_q[39:4];
                line_q[replPtr_q] <= mem_resp_data_i;
                replPtr_q         <= replPtr_q + 1'b1;
            end
        end
    end

    assign resp_valid_o     = respValid_q;
    assign resp_data_o      = respData_q;
    assign resp_ex_valid_o  = respExValid_q;
    assign resp_ex_cause_o  = respExCause_q;
    assign resp_ex_origin_o = respExOrigin_q;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed testbench for icache_fetch_responder: hit table plus hand-written miss/flush/eviction sequences.
module tb_icache_fetch_responder;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic [39:0]  req_vaddr_i;
    logic         req_ready_o;
    logic         flush_i;
    logic         resp_valid_o;
    logic [31:0]  resp_data_o;
    logic         resp_ex_valid_o;
    logic [63:0]  resp_ex_cause_o;
    logic [63:0]  resp_ex_origin_o;
    logic         mem_req_valid_o;
    logic [39:0]  mem_req_addr_o;
    logic         mem_req_ready_i;
    logic         mem_resp_valid_i;
    logic [127:0] mem_resp_data_i;
    logic         mem_resp_error_i;

    int compared   = 0;
    int mismatched = 0;

    icache_fetch_responder #(.NUM_LINES(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_vaddr_i      (req_vaddr_i),
        .req_ready_o      (req_ready_o),
        .flush_i          (flush_i),
        .resp_valid_o     (resp_valid_o),
        .resp_data_o      (resp_data_o),
        .resp_ex_valid_o  (resp_ex_valid_o),
        .resp_ex_cause_o  (resp_ex_cause_o),
        .resp_ex_origin_o (resp_ex_origin_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_error_i (mem_resp_error_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        reqValid;
        logic [39:0] vaddr;
        logic        expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[5];

    localparam logic [127:0] LINE1000 = 128'h00000033_00000022_00000011_00000000;

    function automatic logic [127:0] mkLine(input logic [39:0] base);
        logic [31:0] b;
        b = base[31:0];
        return {b + 32'd12, b + 32'd8, b + 32'd4, b};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle's worth of inputs, then sample point is 1 time unit past the clock edge.
    task automatic applyStimulus(input logic reqValid, input logic [39:0] vaddr, input logic flush,
                                 input logic memReady, input logic memRespValid,
                                 input logic [127:0] memData, input logic memErr);
        req_valid_i      = reqValid;
        req_vaddr_i      = vaddr;
        flush_i          = flush;
        mem_req_ready_i  = memReady;
        mem_resp_valid_i = memRespValid;
        mem_resp_data_i  = memData;
        mem_resp_error_i = memErr;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleInputs();
        req_valid_i      = 1'b0;
        flush_i          = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_error_i = 1'b0;
    endtask

    // Fetch that must miss: checks the refill request, plays the memory side and checks the response.
    task automatic doFetchMiss(input logic [39:0] addr, input logic [127:0] line, input logic err);
        int waitCycles;
        logic [1:0] wsel;
        logic [31:0] expWord;
        wsel = addr[3:2];
        expWord = line[wsel*32 +: 32];
        checkOutput("missReady", {63'b0, req_ready_o}, 64'd1);
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        req_valid_i = 1'b0;
        waitCycles = 0;
        while (!mem_req_valid_o && waitCycles < 8) begin
            applyStimulus(1'b0, addr, 1'b0, 1'b0, 1'b0, '0, 1'b0);
            waitCycles++;
        end
        checkOutput("missReqValid", {63'b0, mem_req_valid_o}, 64'd1);
        checkOutput("missReqLatency", 64'(waitCycles), 64'd0);
        checkOutput("missReqAddr", {24'b0, mem_req_addr_o}, {24'b0, addr[39:4], 4'b0000});
        checkOutput("missNoRespEarly", {63'b0, resp_valid_o}, 64'd0);
        applyStimulus(1'b0, addr, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("missReqDropped", {63'b0, mem_req_valid_o}, 64'd0);
        applyStimulus(1'b0, addr, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, addr, 1'b0, 1'b0, 1'b1, line, err);
        idleInputs();
        checkOutput("missRespValid", {63'b0, resp_valid_o}, 64'd1);
        checkOutput("missRespExValid", {63'b0, resp_ex_valid_o}, {63'b0, err});
        if (err) begin
            checkOutput("missRespCause", resp_ex_cause_o, 64'd1);
            checkOutput("missRespOrigin", resp_ex_origin_o, {24'b0, addr});
            checkOutput("missRespData", {32'b0, resp_data_o}, 64'd0);
        end else begin
            checkOutput("missRespData", {32'b0, resp_data_o}, {32'b0, expWord});
        end
        applyStimulus(1'b0, addr, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("missRespPulse", {63'b0, resp_valid_o}, 64'd0);
    endtask

    task automatic expectHit(input logic [39:0] addr, input logic [31:0] expData);
        applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        req_valid_i = 1'b0;
        checkOutput("hitValid", {63'b0, resp_valid_o}, 64'd1);
        checkOutput("hitData", {32'b0, resp_data_o}, {32'b0, expData});
        checkOutput("hitNoMemReq", {63'b0, mem_req_valid_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 40'h00_0000_1000, 1'b1, 32'h00};
        vecs[1] = '{1'b1, 40'h00_0000_1004, 1'b1, 32'h11};
        vecs[2] = '{1'b1, 40'h00_0000_100C, 1'b1, 32'h33};
        vecs[3] = '{1'b0, 40'h00_0000_1008, 1'b0, 32'h00};
        vecs[4] = '{1'b1, 40'h00_0000_1008, 1'b1, 32'h22};

        rst_i = 1'b1;
        req_vaddr_i = '0;
        mem_resp_data_i = '0;
        idleInputs();
        #1;
        checkOutput("rstReqReady", {63'b0, req_ready_o}, 64'd0);
        checkOutput("rstRespValid", {63'b0, resp_valid_o}, 64'd0);
        checkOutput("rstRespExValid", {63'b0, resp_ex_valid_o}, 64'd0);
        checkOutput("rstMemReqValid", {63'b0, mem_req_valid_o}, 64'd0);
        checkOutput("rstMemReqAddr", {24'b0, mem_req_addr_o}, 64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        checkOutput("postRstReady", {63'b0, req_ready_o}, 64'd1);

        $display("[TB] cold miss at 0x1008");
        doFetchMiss(40'h00_0000_1008, LINE1000, 1'b0);

        $display("[TB] back-to-back hit table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].reqValid, vecs[i].vaddr, 1'b0, 1'b0, 1'b0, '0, 1'b0);
            checkOutput("tblRespValid", {63'b0, resp_valid_o}, {63'b0, vecs[i].expValid});
            if (vecs[i].expValid)
                checkOutput("tblRespData", {32'b0, resp_data_o}, {32'b0, vecs[i].expData});
            checkOutput("tblNoMemReq", {63'b0, mem_req_valid_o}, 64'd0);
        end
        idleInputs();
        applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        $display("[TB] refill error at 0x2000 then re-fetch");
        doFetchMiss(40'h00_0000_2000, mkLine(40'h2000), 1'b1);
        doFetchMiss(40'h00_0000_2000, mkLine(40'h2000), 1'b0);
        expectHit(40'h00_0000_2008, 32'h2008);

`ifdef ICACHE_MISALIGN_CHECK_EN
        $display("[TB] misaligned fetch 0x1002");
        applyStimulus(1'b1, 40'h00_0000_1002, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        req_valid_i = 1'b0;
        checkOutput("misRespValid", {63'b0, resp_valid_o}, 64'd1);
        checkOutput("misExValid", {63'b0, resp_ex_valid_o}, 64'd1);
        checkOutput("misCause", resp_ex_cause_o, 64'd0);
        checkOutput("misOrigin", resp_ex_origin_o, 64'h1002);
        checkOutput("misData", {32'b0, resp_data_o}, 64'd0);
        checkOutput("misNoMemReq", {63'b0, mem_req_valid_o}, 64'd0);
        applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("misNoMemReqLater", {63'b0, mem_req_valid_o}, 64'd0);
`else
        $display("[TB] low address bits ignored at 0x100E");
        expectHit(40'h00_0000_100E, 32'h33);
        checkOutput("lowBitsNoEx", {63'b0, resp_ex_valid_o}, 64'd0);
`endif

        $display("[TB] flush during MISS_WAIT");
        applyStimulus(1'b1, 40'h00_0000_3000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        req_valid_i = 1'b0;
        checkOutput("killReqValid", {63'b0, mem_req_valid_o}, 64'd1);
        applyStimulus(1'b0, 40'h0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 40'h0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("killNoResp", {63'b0, resp_valid_o}, 64'd0);
        applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("killNotReady", {63'b0, req_ready_o}, 64'd0);
        applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b1, mkLine(40'h3000), 1'b0);
        idleInputs();
        checkOutput("killDiscard", {63'b0, resp_valid_o}, 64'd0);
        checkOutput("killBackIdle", {63'b0, req_ready_o}, 64'd1);
        applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("killStillQuiet", {63'b0, resp_valid_o}, 64'd0);
        doFetchMiss(40'h00_0000_1000, LINE1000, 1'b0);

        $display("[TB] eviction after five fills");
        for (int i = 0; i < 5; i++)
            doFetchMiss(40'h00_0000_A000 + 40'(i) * 40'h1000, mkLine(40'h00_0000_A000 + 40'(i) * 40'h1000), 1'b0);
        expectHit(40'h00_0000_B004, 32'hB004);
        applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        doFetchMiss(40'h00_0000_A00C, mkLine(40'h00_0000_A000), 1'b0);

        $display("[TB] flush withdraws refill request");
        applyStimulus(1'b1, 40'h00_0000_F000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        req_valid_i = 1'b0;
        checkOutput("wdReqValid", {63'b0, mem_req_valid_o}, 64'd1);
        applyStimulus(1'b0, 40'h0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        flush_i = 1'b0;
        #1;
        checkOutput("wdReqDropped", {63'b0, mem_req_valid_o}, 64'd0);
        checkOutput("wdNoResp", {63'b0, resp_valid_o}, 64'd0);
        checkOutput("wdReady", {63'b0, req_ready_o}, 64'd1);

        $display("[TB] reset mid-miss");
        applyStimulus(1'b1, 40'h00_0000_5000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        req_valid_i = 1'b0;
        checkOutput("rstMidReqValid", {63'b0, mem_req_valid_o}, 64'd1);
        rst_i = 1'b1;
        #1;
        checkOutput("rstMidDropped", {63'b0, mem_req_valid_o}, 64'd0);
        checkOutput("rstMidAddr", {24'b0, mem_req_addr_o}, 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        checkOutput("rstMidReady", {63'b0, req_ready_o}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/icache_fetch_responder.md
# icache_fetch_responder

Instruction-side responder for the fetch interface: accepts a `req_cpu_icache_t`-style request (`valid`, 40-bit `vaddr`) and returns a `req_icache_cpu_t`-style response (`valid`, 32-bit instruction, `exception_t`). It sits between the fetch stage and the memory refill port. It holds a small fully associative buffer of 128-bit lines (`icache_line_t`) and refills on a miss through a valid/ready request channel plus a response channel. Responses are single-cycle pulses; the fetch side applies no backpressure.

## Interface
- `NUM_LINES`, default 4, number of line entries; a power of two, at least 2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: fetch request valid.
- `req_vaddr_i` in 40: fetch address (`addr_t`).
- `req_ready_o` out 1: request accepted this cycle when high together with `req_valid_i`.
- `flush_i` in 1: fence.i; invalidates all lines and kills any outstanding request.
- `resp_valid_o` out 1: one-cycle response pulse.
- `resp_data_o` out 32: instruction word (`inst_t`).
- `resp_ex_valid_o` out 1: response carries an exception.
- `resp_ex_cause_o` out 64: `exception_cause_t` code.
- `resp_ex_origin_o` out 64: faulting address, `req_vaddr_i` zero-extended (`addrPC_t`).
- `mem_req_valid_o` out 1: line refill request.
- `mem_req_addr_o` out 40: line-aligned address, `{vaddr[39:4], 4'b0}`.
- `mem_req_ready_i` in 1: refill request accepted.
- `mem_resp_valid_i` in 1: refill data valid, one cycle.
- `mem_resp_data_i` in 128: line data; word k is `[32k+31:32k]`.
- `mem_resp_error_i` in 1: refill access fault, qualified by `mem_resp_valid_i`.

## Operation
- Line entry: valid bit, 36-bit tag `vaddr[39:4]`, 128-bit data. Word select is `vaddr[3:2]`.
- States:
  - IDLE:
    - `req_ready_o = !flush_i`.
    - On accept with a hit, register the word; `resp_valid_o` asserts next cycle and the state stays IDLE.
    - On accept with a miss, latch vaddr and go to MISS_REQ.
  - MISS_REQ:
    - `mem_req_valid_o = 1`, with `mem_req_addr_o` stable.
    - On `mem_req_ready_i`, go to MISS_WAIT.
    - On `flush_i` before the handshake, go to IDLE with no response; the withdrawal is legal.
  - MISS_WAIT: on `mem_resp_valid_i`:
    - No error: write the line into the entry at the replacement pointer, set valid, increment the pointer modulo NUM_LINES, respond with the selected word, go to IDLE.
    - Error: no fill and no pointer change. Respond with `resp_ex_valid_o = 1`, cause 1 (instruction access fault), origin = vaddr, data 0. Go to IDLE.
    - On `flush_i` without `mem_resp_valid_i`: go to KILL.
  - KILL: wait for `mem_resp_valid_i`, discard it (no fill, no response), go to IDLE.
- `req_ready_o = 0` in all states other than IDLE.
- Flush:
  - Clears every valid bit in the same edge, in every state.
  - Drops any response scheduled for the next cycle, so `resp_valid_o` is 0 the cycle after `flush_i`.
  - The replacement pointer is not reset.
- Simultaneous `flush_i` and `mem_resp_valid_i` in MISS_WAIT: the response is discarded, state goes to IDLE.
- A lookup never hits on an entry whose fill completes in the same cycle. Only IDLE performs lookups, so this cannot occur.
- Tags are unique: a line is refilled only on a miss.

## Timing
- Reset values: all outputs 0, state IDLE, all valid bits 0, replacement pointer 0.
- Hit latency: 1 cycle from accept to `resp_valid_o`. Back-to-back hits sustain one response per cycle.
- Miss latency: accept at cycle t; `mem_req_valid_o` from t+1; response in the cycle after `mem_resp_valid_i`. All outputs are registered.
- Reset asserted mid-miss returns immediately to reset values. The memory side must tolerate an abandoned request.

## Configuration
- `ICACHE_MISALIGN_CHECK_EN` defined:
  - An accepted request with `vaddr[1:0] != 0` does no lookup and no refill.
  - Next cycle it responds with `resp_ex_valid_o = 1`, cause 0 (instruction address misaligned), origin = vaddr, data 0.
- Not defined: `vaddr[1:0]` is ignored and the request is handled normally.

## Test plan
- Cold miss at 0x00_0000_1008:
  - `mem_req_addr_o = 0x00_0000_1000` one cycle after accept.
  - Return line {W3,W2,W1,W0} = {0x33,0x22,0x11,0x00}; `resp_data_o = 0x22` the following cycle.
- Hits at 0x1000, 0x1004, 0x100C on consecutive cycles: responses 0x00, 0x11, 0x33 on three consecutive cycles, with no `mem_req_valid_o`.
- Refill with `mem_resp_error_i = 1` for 0x2000: `resp_ex_valid_o = 1`, cause 1, origin 0x2000. A re-fetch of 0x2000 misses again.
- `flush_i` in MISS_WAIT, then memory responds 3 cycles later: no response. A later fetch of 0x1000 misses, since the flush invalidated it.
- Fill five distinct lines with NUM_LINES = 4: the fifth evicts the first. A re-fetch of the first line misses; the second line still hits.
- With `ICACHE_MISALIGN_CHECK_EN`, fetch 0x1002: cause 0, origin 0x1002, no memory request.
